// File: rtl/bpred_unit.sv
// Branch prediction unit for the RV32I five-stage pipeline.
//
// Holds a direct-mapped branch target buffer (BTB) and a pattern history table (PHT)
// of saturating counters. MODE selects static not-taken (0), bimodal (1) or gshare (2).
// Lookup is combinational against the IF-stage PC. Training and misprediction
// detection use the instruction resolving in MEM.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_pc                    IF-stage fetch PC
//   pred_taken, pred_next_pc prediction for if_pc
//   upd_*                    resolved instruction in MEM plus its recorded prediction
//   mispredict, redirect_pc  flush request and correct next PC
//   stat_clear               synchronous clear of the statistics counters
//   stat_ctrl, stat_mispred  resolved control transfers and mispredictions (saturating)
module bpred_unit #(
   parameter int unsigned BTB_ENTRIES = 64,
   parameter int unsigned PHT_ENTRIES = 256,
   parameter int unsigned GHR_BITS    = 8,
   parameter int unsigned CTR_BITS    = 2,
   parameter int unsigned MODE        = 2,
   parameter int unsigned STAT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_next_pc,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_is_br,
   input  logic              upd_is_jump,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_pred_taken,
   input  logic [31:0]       upd_pred_next_pc,
   output logic              mispredict,
   output logic [31:0]       redirect_pc,
   input  logic              stat_clear,
   output logic [STAT_W-1:0] stat_ctrl,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W     = 30 - BTB_IDX_W;
   localparam int unsigned PHT_IDX_W = $clog2(PHT_ENTRIES);
   // Weakly not-taken: 2^(CTR_BITS-1)-1
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   // Table storage
   logic                btb_valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0]    btb_tag_q    [BTB_ENTRIES];
   logic [31:0]         btb_target_q [BTB_ENTRIES];
   logic                btb_jump_q   [BTB_ENTRIES];
   logic [CTR_BITS-1:0] pht_q        [PHT_ENTRIES];
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic [STAT_W-1:0]   stat_ctrl_q, stat_mispred_q;

   // Bimodal index, optionally folded with the zero-extended global history.
   function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [31:0]         pc,
                                                      input logic [GHR_BITS-1:0] ghr);
      logic [PHT_IDX_W-1:0] idx;
      logic [PHT_IDX_W-1:0] hist;
      idx  = pc[PHT_IDX_W+1:2];
      hist = '0;
      hist[GHR_BITS-1:0] = ghr;
      if (MODE == 2) idx = idx ^ hist;
      return idx;
   endfunction

   // Lookup side
   logic [BTB_IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0]     lk_tag;
   logic                 lk_hit;
   logic [PHT_IDX_W-1:0] lk_pht_idx;
   logic [31:0]          if_pc_inc;

   assign lk_idx     = if_pc[BTB_IDX_W+1:2];
   assign lk_tag     = if_pc[31:BTB_IDX_W+2];
   assign lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
   assign lk_pht_idx = pht_index(if_pc, ghr_q);
   assign if_pc_inc  = if_pc + 32'd4;

   always_comb begin
      pred_taken = 1'b0;
      if (!rst && (MODE != 0) && lk_hit) begin
         pred_taken = btb_jump_q[lk_idx] || pht_q[lk_pht_idx][CTR_BITS-1];
      end
      pred_next_pc = pred_taken ? btb_target_q[lk_idx] : if_pc_inc;
   end

   // Resolution side
   logic [BTB_IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0]     upd_tag;
   logic                 upd_hit;
   logic [PHT_IDX_W-1:0] upd_pht_idx;
   logic [31:0]          upd_pc_inc;
   logic                 upd_fire;
   logic                 btb_write;
   logic                 btb_inval;
   logic                 pht_write;
   logic                 ctrl_inc;
   logic [CTR_BITS-1:0]  ctr_cur, ctr_next;

   assign upd_idx     = upd_pc[BTB_IDX_W+1:2];
   assign upd_tag     = upd_pc[31:BTB_IDX_W+2];
   assign upd_hit     = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
   assign upd_pht_idx = pht_index(upd_pc, ghr_q);
   assign upd_pc_inc  = upd_pc + 32'd4;
   assign upd_fire    = upd_valid && !rst;

   assign redirect_pc = upd_taken ? upd_target : upd_pc_inc;
   // Compared against the recorded next PC, so aliased hits on non-control
   // instructions are caught too.
   assign mispredict  = upd_fire && (upd_pred_next_pc != redirect_pc);

   assign btb_write = upd_fire && (upd_is_jump || (upd_is_br && upd_taken));
   assign btb_inval = upd_fire && !upd_is_br && !upd_is_jump && upd_hit;
   assign pht_write = upd_fire && upd_is_br;
   assign ctrl_inc  = upd_fire && (upd_is_br || upd_is_jump);

   always_comb begin
      ctr_cur  = pht_q[upd_pht_idx];
      ctr_next = ctr_cur;
      if (upd_taken) begin
         if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
      end else begin
         if (ctr_cur != '0) ctr_next = ctr_cur - CTR_BITS'(1);
      end
   end

   // History shifts only on resolved conditional branches; never speculative.
   always_comb begin
      ghr_d = ghr_q;
      if (pht_write) begin
         ghr_d    = ghr_q << 1;
         ghr_d[0] = upd_taken;
      end
   end

   // BTB valid bits and PHT counters need reset; tag/target/kind are qualified by valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(BTB_ENTRIES); i++) btb_valid_q[i] <= 1'b0;
         for (int i = 0; i < int'(PHT_ENTRIES); i++) pht_q[i] <= CTR_INIT;
         ghr_q <= '0;
      end else begin
         if (btb_write) begin
            btb_valid_q[upd_idx] <= 1'b1;
         end else if (btb_inval) begin
            btb_valid_q[upd_idx] <= 1'b0;
         end
         if (pht_write) pht_q[upd_pht_idx] <= ctr_next;
         ghr_q <= ghr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (btb_write) begin
         btb_tag_q[upd_idx]    <= upd_tag;
         btb_target_q[upd_idx] <= upd_target;
         btb_jump_q[upd_idx]   <= upd_is_jump;
      end
   end

   // Statistics; a clear overrides a coincident increment.
   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         stat_ctrl_q    <= '0;
         stat_mispred_q <= '0;
      end else begin
         if (ctrl_inc && (stat_ctrl_q != '1)) stat_ctrl_q <= stat_ctrl_q + STAT_W'(1);
         if (mispredict && (stat_mispred_q != '1)) begin
            stat_mispred_q <= stat_mispred_q + STAT_W'(1);
         end
      end
   end

   assign stat_ctrl    = stat_ctrl_q;
   assign stat_mispred = stat_mispred_q;

   // Byte offset bits and the recorded direction carry no information here.
   logic unused_bits;
   assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_pred_taken};

endmodule

// File: tb/tb_bpred_unit.sv
// Bench for bpred_unit: three instances (bimodal with 4-bit stats, gshare, static)
// share one stimulus stream. Stimulus pushes expected values into a scoreboard
// queue tagged with the cycle they apply to; a monitor on the falling edge pops
// and compares them.
module tb_bpred_unit;

   localparam int DA = 0;  // MODE 1, STAT_W 4
   localparam int DB = 1;  // MODE 2, STAT_W 32
   localparam int DC = 2;  // MODE 0, STAT_W 32

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        upd_valid, upd_is_br, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_next_pc;
   logic        stat_clear;

   logic        a_pt, b_pt, c_pt, a_mis, b_mis, c_mis;
   logic [31:0] a_npc, b_npc, c_npc, a_red, b_red, c_red;
   logic [3:0]  a_sc, a_sm;
   logic [31:0] b_sc, b_sm, c_sc, c_sm;

   always #5 clk = ~clk;

   bpred_unit #(.BTB_ENTRIES(64), .PHT_ENTRIES(256), .GHR_BITS(8), .CTR_BITS(2),
                .MODE(1), .STAT_W(4)) u_dut_a (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(a_pt), .pred_next_pc(a_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
      .mispredict(a_mis), .redirect_pc(a_red), .stat_clear(stat_clear),
      .stat_ctrl(a_sc), .stat_mispred(a_sm));

   bpred_unit #(.BTB_ENTRIES(64), .PHT_ENTRIES(256), .GHR_BITS(8), .CTR_BITS(2),
                .MODE(2), .STAT_W(32)) u_dut_b (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(b_pt), .pred_next_pc(b_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
      .mispredict(b_mis), .redirect_pc(b_red), .stat_clear(stat_clear),
      .stat_ctrl(b_sc), .stat_mispred(b_sm));

   bpred_unit #(.BTB_ENTRIES(64), .PHT_ENTRIES(256), .GHR_BITS(8), .CTR_BITS(2),
                .MODE(0), .STAT_W(32)) u_dut_c (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(c_pt), .pred_next_pc(c_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
      .mispredict(c_mis), .redirect_pc(c_red), .stat_clear(stat_clear),
      .stat_ctrl(c_sc), .stat_mispred(c_sm));

   // Scoreboard
   typedef struct {
      int          cyc;
      int          dut;
      int          fld;   // 0 pred_taken, 1 pred_next_pc, 2 mispredict, 3 redirect_pc,
                          // 4 stat_ctrl, 5 stat_mispred
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cur_cyc  = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] observe(input int d, input int f);
      logic [31:0] v [6];
      case (d)
         DA: v = '{32'(a_pt), a_npc, 32'(a_mis), a_red, 32'(a_sc), 32'(a_sm)};
         DB: v = '{32'(b_pt), b_npc, 32'(b_mis), b_red, b_sc, b_sm};
         default: v = '{32'(c_pt), c_npc, 32'(c_mis), c_red, c_sc, c_sm};
      endcase
      return v[f];
   endfunction

   task automatic exp_v(input int d, input int f, input logic [31:0] e, input string n);
      exp_t t;
      t.cyc = cur_cyc; t.dut = d; t.fld = f; t.exp = e; t.name = n;
      sb_q.push_back(t);
   endtask

   task automatic exp_lookup(input int d, input logic pt, input logic [31:0] npc,
                             input string n);
      exp_v(d, 0, 32'(pt), {n, " pred_taken"});
      exp_v(d, 1, npc, {n, " pred_next_pc"});
   endtask

   task automatic exp_mis(input int d, input logic m, input logic [31:0] red, input string n);
      exp_v(d, 2, 32'(m), {n, " mispredict"});
      exp_v(d, 3, red, {n, " redirect_pc"});
   endtask

   task automatic exp_stats(input int d, input logic [31:0] ctl, input logic [31:0] misp,
                            input string n);
      exp_v(d, 4, ctl, {n, " stat_ctrl"});
      exp_v(d, 5, misp, {n, " stat_mispred"});
   endtask

   // Monitor
   initial begin
      exp_t        t;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cur_cyc) begin
            t   = sb_q.pop_front();
            act = observe(t.dut, t.fld);
            n_checks++;
            if (act !== t.exp) begin
               n_fail++;
               $display("FAIL %s (dut %0d, cycle %0d): got 0x%0h, expected 0x%0h",
                        t.name, t.dut, cur_cyc, act, t.exp);
            end
         end
      end
   end

   // Stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
      cur_cyc++;
   endtask

   task automatic idle();
      upd_valid = 1'b0; upd_pc = '0; upd_is_br = 1'b0; upd_is_jump = 1'b0;
      upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_next_pc = '0;
      stat_clear = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                      input logic tkn, input logic [31:0] tgt, input logic [31:0] pnpc);
      upd_valid = 1'b1; upd_pc = pc; upd_is_br = br; upd_is_jump = jmp;
      upd_taken = tkn; upd_target = tgt; upd_pred_next_pc = pnpc;
      upd_pred_taken = (pnpc != pc + 32'd4);
   endtask

   task automatic reset_all();
      tick();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic        tkn, pt;
      logic [31:0] npc;

      // Reset with a live update on the input: prediction forced, update dropped
      rst = 1'b1;
      idle();
      if_pc = 32'h60;
      upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 32'h104);
      tick();
      for (int d = 0; d < 3; d++) begin
         exp_lookup(d, 1'b0, 32'h64, "in-reset lookup");
         exp_v(d, 2, 32'd0, "in-reset mispredict");
      end
      tick();
      rst = 1'b0;
      idle();
      for (int d = 0; d < 3; d++) begin
         exp_lookup(d, 1'b0, 32'h64, "post-reset lookup");
         exp_stats(d, 32'd0, 32'd0, "post-reset");
      end
      tick();
      if_pc = 32'h100;
      exp_lookup(DA, 1'b0, 32'h104, "update suppressed in reset");

      // Taken branch trains BTB and counter
      tick();
      upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 32'h104);
      exp_lookup(DA, 1'b0, 32'h104, "cold lookup");
      exp_mis(DA, 1'b1, 32'h80, "br taken");
      exp_mis(DB, 1'b1, 32'h80, "br taken");
      tick();
      idle();
      exp_lookup(DA, 1'b1, 32'h80, "bimodal trained");
      exp_lookup(DB, 1'b0, 32'h104, "gshare history moved index");
      exp_lookup(DC, 1'b0, 32'h104, "static never taken");
      exp_stats(DA, 32'd1, 32'd1, "after first branch");

      // Same branch not-taken; same-cycle lookup sees pre-update state
      tick();
      upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 32'h80);
      exp_lookup(DA, 1'b1, 32'h80, "same-cycle lookup pre-update");
      exp_mis(DA, 1'b1, 32'h104, "br not-taken");
      tick();
      idle();
      exp_lookup(DA, 1'b0, 32'h104, "counter back to weak");

      // Alias: jal installs, other tag misses, non-control invalidates
      tick();
      upd(32'h100, 1'b0, 1'b1, 1'b1, 32'h400, 32'h104);
      exp_mis(DA, 1'b1, 32'h400, "jal");
      tick();
      idle();
      exp_lookup(DA, 1'b1, 32'h400, "jal installed");
      exp_lookup(DB, 1'b1, 32'h400, "gshare jump");
      exp_lookup(DC, 1'b0, 32'h104, "static ignores btb");
      tick();
      if_pc = 32'h200;
      upd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h400);
      exp_lookup(DA, 1'b0, 32'h204, "alias tag miss");
      exp_mis(DA, 1'b1, 32'h104, "alias non-control");
      tick();
      idle();
      if_pc = 32'h100;
      exp_lookup(DA, 1'b0, 32'h104, "alias entry invalidated");
      exp_stats(DA, 32'd3, 32'd4, "after alias");
      exp_stats(DC, 32'd3, 32'd4, "after alias");

      // Statistics saturation and clear priority
      reset_all();
      for (int k = 0; k < 17; k++) begin
         upd(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end
      idle();
      exp_stats(DA, 32'd0, 32'd15, "4-bit saturate");
      exp_stats(DB, 32'd0, 32'd17, "32-bit count");
      tick();
      upd(32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      exp_stats(DA, 32'd0, 32'd0, "clear beats increment");
      exp_stats(DB, 32'd0, 32'd0, "clear beats increment");
      tick();
      idle();
      exp_stats(DA, 32'd1, 32'd1, "count after clear");

      // Reset mid-update discards the update
      tick();
      rst = 1'b1;
      if_pc = 32'h700;
      upd(32'h700, 1'b0, 1'b1, 1'b1, 32'h900, 32'h704);
      exp_v(DA, 2, 32'd0, "mispredict masked in reset");
      exp_lookup(DA, 1'b0, 32'h704, "lookup in reset");
      tick();
      rst = 1'b0;
      idle();
      for (int d = 0; d < 3; d++) exp_lookup(d, 1'b0, 32'h704, "reset discards update");
      exp_stats(DA, 32'd0, 32'd0, "stats after reset");

      // Gshare on an alternating branch: learned after the history settles
      reset_all();
      if_pc = 32'h40;
      for (int k = 0; k < 20; k++) begin
         tkn = (k % 2 == 0);
         pt  = (k >= 10) && tkn;
         npc = pt ? 32'h20 : 32'h44;
         upd(32'h40, 1'b1, 1'b0, tkn, 32'h20, npc);
         exp_lookup(DB, pt, npc, "gshare alternating");
         exp_v(DB, 2, 32'((k < 10) && tkn), "gshare alternating mispredict");
         if (k == 12) exp_stats(DB, 32'd12, 32'd5, "gshare warmed");
         tick();
      end
      idle();
      exp_stats(DB, 32'd20, 32'd5, "gshare final");
      exp_stats(DA, 32'd15, 32'd5, "ctrl saturates");

      tick();
      tick();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bpred_unit.md
# bpred_unit

Parametrised branch prediction unit for the RV32I five-stage pipeline. It contains a direct-mapped branch target buffer (BTB) and a pattern history table (PHT) of saturating counters, with static, bimodal and gshare modes. Lookup is combinational against the IF-stage PC and drives next-PC selection. Update and misprediction detection use the instruction resolving in MEM, which replaces the fixed fetch of PC+4 with a flush on every taken branch, jal or jalr.

## Interface
- BTB_ENTRIES, 64, BTB depth; power of two, at least 2.
- PHT_ENTRIES, 256, PHT depth; power of two.
- GHR_BITS, 8, global history length; must not exceed log2(PHT_ENTRIES).
- CTR_BITS, 2, PHT counter width; at least 1.
- MODE, 2, prediction mode: 0 static not-taken, 1 bimodal, 2 gshare.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_pc  in  32  IF-stage fetch PC.
- pred_taken  out  1  prediction for if_pc.
- pred_next_pc  out  32  predicted next fetch PC.
- upd_valid  in  1  a valid instruction is in MEM this cycle.
- upd_pc  in  32  PC of that instruction.
- upd_is_br  in  1  instruction is a conditional branch (op_br).
- upd_is_jump  in  1  instruction is jal or jalr.
- upd_taken  in  1  resolved direction; always 1 for a jump.
- upd_target  in  32  resolved target; for jal/jalr, bit 0 is already cleared.
- upd_pred_taken  in  1  pred_taken recorded when this instruction was fetched.
- upd_pred_next_pc  in  32  pred_next_pc recorded when this instruction was fetched.
- mispredict  out  1  flush IF/ID and ID/EX and redirect fetch.
- redirect_pc  out  32  correct next PC: upd_target if upd_taken, otherwise upd_pc+4.
- stat_clear  in  1  synchronous clear of both statistics counters.
- stat_ctrl  out  STAT_W  count of resolved branches and jumps.
- stat_mispred  out  STAT_W  count of mispredictions.

## Operation
- Address fields:
  - BTB index is pc[log2(BTB_ENTRIES)+1:2].
  - BTB tag is the remaining high PC bits.
  - pc[1:0] are ignored.
- Each BTB entry holds valid, tag, target[31:0] and is_jump.
- PHT index:
  - Bimodal (MODE 1): pc[log2(PHT_ENTRIES)+1:2].
  - Gshare (MODE 2): the bimodal index XOR the zero-extended GHR.
- Lookup:
  - hit = valid && tag match.
  - pred_taken = (MODE != 0) && hit && (is_jump || counter MSB).
  - pred_next_pc = pred_taken ? entry target : if_pc+4.
- mispredict = upd_valid && (upd_pred_next_pc != (upd_taken ? upd_target : upd_pc+4)).
- A non-control instruction that was predicted taken through an alias is therefore a misprediction.
- Update, at the clock edge, only when upd_valid is high:
  - Taken branch or jump: write the BTB entry with valid=1, tag, target=upd_target and is_jump=upd_is_jump. An existing entry at that index is overwritten.
  - upd_is_br: update the PHT counter at the index computed from upd_pc and the current (pre-shift) GHR. Increment on taken, decrement on not-taken, saturating at 0 and at 2^CTR_BITS−1. Then set GHR = {GHR[GHR_BITS-2:0], upd_taken}.
  - Neither branch nor jump, and a BTB hit on upd_pc: clear that entry's valid bit.
  - A not-taken branch leaves its BTB entry unchanged.
- GHR is architectural: it is updated only at resolution and never speculatively, so no recovery is needed.
- Statistics:
  - stat_ctrl increments on upd_valid && (upd_is_br || upd_is_jump).
  - stat_mispred increments on mispredict.
  - Both saturate at all-ones.
  - When stat_clear and an increment coincide, the counter becomes 0.
- MODE 0: tables are still written but never consulted; pred_next_pc = if_pc+4.

## Timing
- Lookup and mispredict/redirect_pc are combinational, with zero-cycle latency.
- An update is visible to a lookup starting the cycle after the edge.
- A lookup and an update to the same entry in the same cycle: the lookup returns the pre-update contents.
- Reset, while rst is high:
  - pred_taken = 0 and pred_next_pc = if_pc+4.
  - mispredict = 0 and all updates are suppressed.
- State after reset:
  - All BTB valid bits = 0.
  - All PHT counters = 2^(CTR_BITS−1)−1 (weakly not-taken, 01 for 2-bit counters).
  - GHR = 0.
  - stat_ctrl = stat_mispred = 0.
- Reset asserted mid-operation discards any in-flight update on that edge.
- Outputs redirect_pc, stat_ctrl and stat_mispred have no handshake. The datapath flushes on mispredict in the same cycle and loads the PC from redirect_pc.

## Test plan
- Reset then lookup 0x60 -> pred_taken=0, pred_next_pc=0x64; stats 0.
- MODE 1: branch at 0x100 resolves taken to 0x80, with upd_pred_next_pc=0x104 -> mispredict=1, redirect_pc=0x80. Next cycle lookup 0x100 -> pred_taken=1, pred_next_pc=0x80.
- Continue MODE 1: same branch resolves not-taken, with upd_pred_next_pc=0x80 -> mispredict=1, redirect_pc=0x104. Lookup 0x100 -> pred_taken=0 (counter back to 01); the BTB entry stays valid.
- Alias: jal at 0x100 to 0x400 is installed, then lookup 0x200 (same index, different tag) -> pred_taken=0. A non-control instruction at 0x100 with upd_pred_next_pc=0x400 -> mispredict=1, redirect_pc=0x104, and the entry is invalidated.
- MODE 2: alternating taken/not-taken branch at 0x40 over 20 resolutions -> stat_mispred stops increasing after warm-up; stat_ctrl=20.
- Saturation: STAT_W=4, 17 mispredicts -> stat_mispred=15. stat_clear on the same cycle as an increment -> 0. rst mid-update -> post-reset lookup of the updated PC returns pred_taken=0.
